// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: valid-mode 2D convolution, one MAC tap per cycle.
// Image/kernel on 1-cycle-latency read ports, results on a write port.
module conv2d_stream_engine #(
    parameter int IMG_H  = 8,
    parameter int IMG_W  = 8,
    parameter int K      = 2,
    parameter int DATA_W = 32,
    parameter int SHIFT  = 0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     tstart,
    input  logic                                     relu_en,
    output logic [$clog2(IMG_H*IMG_W)-1:0]           img_addr,
    output logic                                     img_rd_en,
    input  logic [DATA_W-1:0]                        img_rd_data,
    output logic [((K*K > 1) ? $clog2(K*K) : 1)-1:0] ker_addr,
    output logic                                     ker_rd_en,
    input  logic [DATA_W-1:0]                        ker_rd_data,
    output logic [$clog2(IMG_H*IMG_W)-1:0]           out_addr,
    output logic                                     out_wr_en,
    output logic [DATA_W-1:0]                        out_wr_data,
    output logic                                     busy,
    output logic                                     done
);
    localparam int OUT_H  = IMG_H - K + 1;
    localparam int OUT_W  = IMG_W - K + 1;
    localparam int IMG_AW = $clog2(IMG_H*IMG_W);
    localparam int KER_AW = (K*K > 1) ? $clog2(K*K) : 1;
    localparam int PW     = 2*DATA_W;
    localparam int ACC_W  = PW + KER_AW;

    localparam logic [IMG_AW-1:0] K_M1     = IMG_AW'(K - 1);
    localparam logic [IMG_AW-1:0] OW_M1    = IMG_AW'(OUT_W - 1);
    localparam logic [IMG_AW-1:0] OH_M1    = IMG_AW'(OUT_H - 1);
    localparam logic [IMG_AW-1:0] A_ONE    = IMG_AW'(1);
    localparam logic [IMG_AW-1:0] ROW_STEP = IMG_AW'(IMG_W - K + 1);
    localparam logic [IMG_AW-1:0] PIX_STEP = IMG_AW'(K);
    localparam logic [KER_AW-1:0] K_ONE    = KER_AW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t state, state_n;
    logic [1:0] drain_cnt;
    logic       relu_q;
    logic       issue;

    logic [IMG_AW-1:0] kx, ky, ox, oy;
    logic [IMG_AW-1:0] tap_off, pix_base;
    logic [KER_AW-1:0] ker_a;
    logic last_kx, last_ky, last_tap, last_ox, last_oy, last_pix;

    logic              s1_v, s1_first, s1_last;
    logic [IMG_AW-1:0] s1_addr;
    logic              s2_v, s2_first, s2_last;
    logic [IMG_AW-1:0] s2_addr;

    logic signed [PW-1:0]    img_x, ker_x, prod;
    logic signed [ACC_W-1:0] acc, prod_ext, sum, scaled, res;

    assign last_kx  = (kx == K_M1);
    assign last_ky  = (ky == K_M1);
    assign last_tap = last_kx && last_ky;
    assign last_ox  = (ox == OW_M1);
    assign last_oy  = (oy == OH_M1);
    assign last_pix = last_tap && last_ox && last_oy;

    assign img_addr  = pix_base + tap_off;
    assign ker_addr  = ker_a;
    assign img_rd_en = issue;
    assign ker_rd_en = issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            relu_q    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
            else                drain_cnt <= '0;
            if (state == IDLE && tstart) relu_q <= relu_en;
        end
    end

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: if (tstart) state_n = ISSUE;
            ISSUE: begin
                issue = 1'b1;
                busy  = 1'b1;
                if (last_pix) state_n = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == 2'd2) state_n = FIN;
            end
            FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Tap walk; every counter wraps to zero after the final tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kx       <= '0;
            ky       <= '0;
            ox       <= '0;
            oy       <= '0;
            tap_off  <= '0;
            pix_base <= '0;
            ker_a    <= '0;
        end else if (issue) begin
            ker_a <= last_tap ? '0 : ker_a + K_ONE;
            if (!last_kx) begin
                kx      <= kx + A_ONE;
                tap_off <= tap_off + A_ONE;
            end else if (!last_ky) begin
                kx      <= '0;
                ky      <= ky + A_ONE;
                tap_off <= tap_off + ROW_STEP;
            end else begin
                kx      <= '0;
                ky      <= '0;
                tap_off <= '0;
                if (!last_ox) begin
                    ox       <= ox + A_ONE;
                    pix_base <= pix_base + A_ONE;
                end else if (!last_oy) begin
                    ox       <= '0;
                    oy       <= oy + A_ONE;
                    pix_base <= pix_base + PIX_STEP;
                end else begin
                    ox       <= '0;
                    oy       <= '0;
                    pix_base <= '0;
                end
            end
        end
    end

    assign img_x = {{DATA_W{img_rd_data[DATA_W-1]}}, img_rd_data};
    assign ker_x = {{DATA_W{ker_rd_data[DATA_W-1]}}, ker_rd_data};

    always_comb begin
        prod_ext = {{KER_AW{prod[PW-1]}}, prod};
        sum      = s2_first ? prod_ext : acc + prod_ext;
        scaled   = sum >>> SHIFT;
        res      = (relu_q && scaled[ACC_W-1]) ? '0 : scaled;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v        <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_addr     <= '0;
            s2_v        <= 1'b0;
            s2_first    <= 1'b0;
            s2_last     <= 1'b0;
            s2_addr     <= '0;
            prod        <= '0;
            acc         <= '0;
            out_wr_en   <= 1'b0;
            out_addr    <= '0;
            out_wr_data <= '0;
        end else begin
            s1_v     <= issue;
            s1_first <= (kx == '0) && (ky == '0);
            s1_last  <= last_tap;
            s1_addr  <= pix_base;
            s2_v     <= s1_v;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_addr  <= s1_addr;
            prod     <= img_x * ker_x;
            if (s2_v) acc <= sum;
            out_wr_en <= s2_v && s2_last;
            if (s2_v && s2_last) begin
                out_addr    <= s2_addr;
                out_wr_data <= res[DATA_W-1:0];
            end
        end
    end
endmodule
